// File: rtl/mealy_code_lock_pkg.sv
// Shared definitions for the button-sequence code lock: FSM state encoding,
// press-classification codes and the code-entry width helper.
package mealy_code_lock_pkg;

  typedef enum logic [0:0] {
    ST_ARMED   = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_e;

  // Classification of the button vector seen in one cycle
  localparam logic [1:0] PR_IDLE  = 2'd0;
  localparam logic [1:0] PR_VALID = 2'd1;
  localparam logic [1:0] PR_MULTI = 2'd2;

  // Width of one code entry; never narrower than one bit
  function automatic int unsigned btn_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mealy_code_lock_lock_timer.sv
// Down-counter used to time the lockout. Load sets CYC-1; it then counts down
// while enabled and sticks at zero, which is reported as expired.
module lock_timer #(
  parameter int unsigned CYC = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (CYC <= 2) ? 1 : $clog2(CYC);
  localparam logic [CW-1:0] LoadVal = CW'(CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mealy_code_lock.sv
// Mealy button-sequence lock. Counts correct presses against CODE, strobes z
// combinationally on the final correct press, counts consecutive failures and
// enters a timed lockout after MAX_FAIL of them.
module mealy_code_lock
  import mealy_code_lock_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 2,
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [CODE_LEN*btn_w(NUM_BTN)-1:0] CODE = 4'b1000,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_BTN-1:0]              btn,
  output logic                            z,
  output logic                            locked,
  output logic [$clog2(CODE_LEN)-1:0]     progress,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

  localparam int unsigned BTN_W = btn_w(NUM_BTN);
  localparam int unsigned PW    = $clog2(CODE_LEN);
  localparam int unsigned FW    = $clog2(MAX_FAIL + 1);
  localparam logic [PW-1:0] LastIdx = PW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FailMax = FW'(MAX_FAIL);

  function automatic logic [BTN_W-1:0] code_entry(input logic [PW-1:0] idx);
    return CODE[idx*BTN_W +: BTN_W];
  endfunction

  function automatic logic [1:0] press_class(input logic [NUM_BTN-1:0] b);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      n = n + 32'(b[i]);
    end
    if (n == 0) return PR_IDLE;
    if (n == 1) return PR_VALID;
    return PR_MULTI;
  endfunction

  // Index of the highest set bit; only meaningful for a valid single press
  function automatic logic [BTN_W-1:0] press_idx(input logic [NUM_BTN-1:0] b);
    logic [BTN_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (b[i]) idx = BTN_W'(i);
    end
    return idx;
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] progress_q, progress_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [1:0]    cls;
  logic [BTN_W-1:0] idx;
  logic          hit, first_hit, failed;
  logic          timer_load, timer_en, timer_expired;

  lock_timer #(
    .CYC(LOCKOUT_CYC)
  ) u_lock_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  // Next-state, counters and the Mealy unlock strobe
  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    fail_d     = fail_q;
    z          = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    failed     = 1'b0;
    cls        = press_class(btn);
    idx        = press_idx(btn);
    hit        = (cls == PR_VALID) && (idx == code_entry(progress_q));
    first_hit  = (cls == PR_VALID) && (idx == code_entry('0));

    unique case (state_q)
      ST_ARMED: begin
        unique case (cls)
          PR_IDLE:  ;
          PR_VALID: failed = !hit;
          PR_MULTI: failed = 1'b1;
          default:  failed = 1'b1;
        endcase
        if (hit) begin
          if (progress_q == LastIdx) begin
            // Final correct press wins over any pending failure count
            z          = 1'b1;
            progress_d = '0;
            fail_d     = '0;
          end else begin
            progress_d = progress_q + 1'b1;
          end
        end else if (failed) begin
          // A wrong press may itself be a correct first entry
          progress_d = first_hit ? PW'(1) : '0;
          if (fail_q != FailMax) fail_d = fail_q + 1'b1;
          if ((fail_q + 1'b1) == FailMax) begin
            state_d    = ST_LOCKOUT;
            timer_load = 1'b1;
            progress_d = '0;
          end
        end
      end
      ST_LOCKOUT: begin
        timer_en = 1'b1;
        if (timer_expired) begin
          state_d    = ST_ARMED;
          fail_d     = '0;
          progress_d = '0;
        end
      end
      default: state_d = ST_ARMED;
    endcase

    if (reset) z = 1'b0;
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      progress_q <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      fail_q     <= fail_d;
    end
  end

  assign locked     = (state_q == ST_LOCKOUT);
  assign progress   = progress_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_mealy_code_lock.sv
// Self-checking bench: a vector table drives the default two-button lock,
// hand-written sequences exercise a four-button, six-entry instance.
module tb_mealy_code_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       reset_a = 1'b1;
  logic [1:0] btn_a = 2'b00;
  logic       z_a, locked_a;
  logic [1:0] progress_a;
  logic [1:0] fail_a;

  mealy_code_lock u_dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .btn       (btn_a),
    .z         (z_a),
    .locked    (locked_a),
    .progress  (progress_a),
    .fail_count(fail_a)
  );

  // Parametrised instance: entries {2,0,3,3,1,0}, entry 0 in the low bits
  localparam logic [11:0] CodeB = 12'b00_01_11_11_00_10;
  logic       reset_b = 1'b1;
  logic [3:0] btn_b = 4'b0000;
  logic       z_b, locked_b;
  logic [2:0] progress_b;
  logic [1:0] fail_b;

  mealy_code_lock #(
    .NUM_BTN    (4),
    .CODE_LEN   (6),
    .CODE       (CodeB),
    .MAX_FAIL   (2),
    .LOCKOUT_CYC(5)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset_b),
    .btn       (btn_b),
    .z         (z_b),
    .locked    (locked_b),
    .progress  (progress_b),
    .fail_count(fail_b)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected values describe the cycle in which the inputs are applied:
  // z for this press, and the registered outputs before the next edge.
  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic       z;
    int         prog;
    int         fail;
    logic       lck;
    logic       chk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [1:0] b, input logic ez, input int p,
                     input int f, input logic l, input logic c);
    vec_t v;
    v.rst = rst; v.btn = b; v.z = ez; v.prog = p; v.fail = f; v.lck = l; v.chk = c;
    vecs.push_back(v);
  endtask

  task automatic step_b(input logic r, input logic [3:0] b);
    @(negedge clk);
    reset_b = r;
    btn_b = b;
    #1;
  endtask

  initial begin
    // Reset hold with P1 pressed
    add(1, 2'b01, 0, 0, 0, 0, 0);
    add(1, 2'b01, 0, 0, 0, 0, 1);
    add(1, 2'b01, 0, 0, 0, 0, 1);
    // Default code P1,P1,P1,P2
    add(0, 2'b01, 0, 0, 0, 0, 1);
    add(0, 2'b01, 0, 1, 0, 0, 1);
    add(0, 2'b01, 0, 2, 0, 0, 1);
    add(0, 2'b10, 1, 3, 0, 0, 1);
    // Held P1 stream 01,01,01,01,10,01
    add(0, 2'b01, 0, 0, 0, 0, 1);
    add(0, 2'b01, 0, 1, 0, 0, 1);
    add(0, 2'b01, 0, 2, 0, 0, 1);
    add(0, 2'b01, 0, 3, 0, 0, 1);
    add(0, 2'b10, 0, 1, 1, 0, 1);
    add(0, 2'b01, 0, 0, 2, 0, 1);
    add(0, 2'b00, 0, 1, 2, 0, 1);
    // Completing the code with fail_count one short of lockout still succeeds
    add(0, 2'b01, 0, 1, 2, 0, 1);
    add(0, 2'b01, 0, 2, 2, 0, 1);
    add(0, 2'b10, 1, 3, 2, 0, 1);
    // Three wrong presses trigger lockout
    add(0, 2'b10, 0, 0, 0, 0, 1);
    add(0, 2'b10, 0, 0, 1, 0, 1);
    add(0, 2'b10, 0, 0, 2, 0, 1);
    // Locked for exactly 16 cycles, correct code ignored
    for (int k = 0; k < 16; k++) begin
      add(0, (k < 3) ? 2'b01 : ((k == 3) ? 2'b10 : 2'b00), 0, 0, 3, 1, 1);
    end
    // After expiry the code works again
    add(0, 2'b01, 0, 0, 0, 0, 1);
    add(0, 2'b01, 0, 1, 0, 0, 1);
    add(0, 2'b01, 0, 2, 0, 0, 1);
    add(0, 2'b10, 1, 3, 0, 0, 1);
    // Multi-press at progress 2
    add(0, 2'b01, 0, 0, 0, 0, 1);
    add(0, 2'b01, 0, 1, 0, 0, 1);
    add(0, 2'b11, 0, 2, 0, 0, 1);
    // Idle gaps between presses
    add(0, 2'b01, 0, 0, 1, 0, 1);
    add(0, 2'b00, 0, 1, 1, 0, 1);
    add(0, 2'b01, 0, 1, 1, 0, 1);
    add(0, 2'b00, 0, 2, 1, 0, 1);
    add(0, 2'b00, 0, 2, 1, 0, 1);
    add(0, 2'b01, 0, 2, 1, 0, 1);
    add(0, 2'b10, 1, 3, 1, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_a = vecs[i].rst;
      btn_a = vecs[i].btn;
      #1;
      check($sformatf("a_v%0d_z", i), int'(z_a), int'(vecs[i].z));
      if (vecs[i].chk) begin
        check($sformatf("a_v%0d_progress", i), int'(progress_a), vecs[i].prog);
        check($sformatf("a_v%0d_fail", i), int'(fail_a), vecs[i].fail);
        check($sformatf("a_v%0d_locked", i), int'(locked_a), int'(vecs[i].lck));
      end
    end

    // Parametrised instance: full six-press code
    step_b(1, 4'b0000);
    step_b(1, 4'b0000);
    step_b(0, 4'b0100);
    check("b_rst_progress", int'(progress_b), 0);
    check("b_rst_fail", int'(fail_b), 0);
    check("b_rst_locked", int'(locked_b), 0);
    check("b_p0_z", int'(z_b), 0);
    step_b(0, 4'b0001);
    check("b_p1_progress", int'(progress_b), 1);
    step_b(0, 4'b1000);
    check("b_p2_progress", int'(progress_b), 2);
    step_b(0, 4'b1000);
    check("b_p3_progress", int'(progress_b), 3);
    step_b(0, 4'b0010);
    check("b_p4_progress", int'(progress_b), 4);
    check("b_p4_z", int'(z_b), 0);
    step_b(0, 4'b0001);
    check("b_p5_progress", int'(progress_b), 5);
    check("b_final_z", int'(z_b), 1);
    step_b(0, 4'b0000);
    check("b_after_progress", int'(progress_b), 0);
    check("b_after_z", int'(z_b), 0);

    // Reset at progress 4, with the correct fifth press present
    step_b(0, 4'b0100);
    step_b(0, 4'b0001);
    step_b(0, 4'b1000);
    step_b(0, 4'b1000);
    step_b(1, 4'b0010);
    check("b_midrst_progress", int'(progress_b), 4);
    check("b_midrst_z", int'(z_b), 0);
    step_b(0, 4'b0000);
    check("b_postrst_progress", int'(progress_b), 0);

    // Two failures lock; reset mid-lockout
    step_b(0, 4'b0010);
    check("b_f0_fail", int'(fail_b), 0);
    step_b(0, 4'b0010);
    check("b_f1_fail", int'(fail_b), 1);
    check("b_f1_locked", int'(locked_b), 0);
    step_b(0, 4'b0000);
    check("b_lock_locked", int'(locked_b), 1);
    check("b_lock_fail", int'(fail_b), 2);
    step_b(0, 4'b0100);
    check("b_lock_ignore_z", int'(z_b), 0);
    check("b_lock_ignore_progress", int'(progress_b), 0);
    step_b(1, 4'b0000);
    check("b_lockrst_locked", int'(locked_b), 1);
    step_b(0, 4'b0000);
    check("b_unlock_locked", int'(locked_b), 0);
    check("b_unlock_fail", int'(fail_b), 0);
    check("b_unlock_progress", int'(progress_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
